// File: rtl/seq_mult_ctrl_if.sv
// Request/result handshake bundle for seq_mult_ctrl.
// master: requester side (drives operand size, consumes product).
// slave:  the controller.
interface seq_mult_ctrl_if #(
    parameter int unsigned P         = 2,
    parameter int unsigned MAX_WIDTH = 16
);
    localparam int unsigned NMAX = MAX_WIDTH / P;
    localparam int unsigned BSW  = $clog2(NMAX) + 1;

    logic                   in_valid;
    logic                   in_ready;
    logic [BSW-1:0]         bit_size;
    logic                   signed_i;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*MAX_WIDTH-1:0] prod;

    modport master (
        output in_valid, bit_size, signed_i, out_ready,
        input  in_ready, out_valid, prod
    );

    modport slave (
        input  in_valid, bit_size, signed_i, out_ready,
        output in_ready, out_valid, prod
    );
endinterface

// File: rtl/seq_mult_ctrl.sv
// Sequencer and result collector for the digit-serial multiplier datapath.
// Walks the partial-product schedule column by column, drives the datapath
// selects/strobes, and assembles the returned P-bit digits into the product.
// Optional feature: define SEQ_MULT_CTRL_SIGNED_EN to enable Baugh-Wooley
// signed operation (signed_i honoured, correction flags, sign-extended prod).
module seq_mult_ctrl #(
    parameter int unsigned P         = 2,
    parameter int unsigned MAX_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_mult_ctrl_if.slave   bus,
    output logic             start,
    output logic [4*P-1:0]   init_sum,
    output logic [2:0]       mux_sel_a,
    output logic [2:0]       mux_sel_b,
    output logic             count_down,
    output logic             count_last2,
    output logic             last_out,
    output logic             invert_first_bit,
    output logic             invert_second_row,
    output logic             place_one,
    output logic [1:0]       count_shift_input,
    input  logic [P-1:0]     p
);
    localparam int unsigned NMAX = MAX_WIDTH / P;
    localparam int unsigned NW   = $clog2(NMAX) + 1;
    localparam int unsigned PW   = 2 * MAX_WIDTH;

`ifdef SEQ_MULT_CTRL_SIGNED_EN
    localparam bit SignedEn = 1'b1;
`else
    localparam bit SignedEn = 1'b0;
`endif

    typedef logic [NW-1:0] cnt_t;
    typedef logic [2:0]    idx_t;
    typedef enum logic [2:0] {StIdle, StStart, StRun, StLast, StFlush, StDone} state_e;

    state_e        state_q, state_d;
    cnt_t          n_q, n_d;
    logic          sgn_q, sgn_d;
    cnt_t          k_q, k_d;
    idx_t          i_q, i_d;
    cnt_t          dig_q, dig_d;
    logic          cap_q, cap_d;
    logic [PW-1:0] prod_q, prod_d;

    cnt_t n_req, k_nx, last_col;
    idx_t j_cur, i_hi, lo_nx, nm1;
    int unsigned ext_lsb;

    // Zero/oversized requests fall back to the widest operand.
    assign n_req = (bus.bit_size == '0 || bus.bit_size > cnt_t'(NMAX)) ? cnt_t'(NMAX)
                                                                      : bus.bit_size;
    assign j_cur    = idx_t'(k_q) - i_q;
    assign nm1      = idx_t'(n_q - 1'b1);
    assign i_hi     = (k_q < n_q) ? idx_t'(k_q) : nm1;
    assign k_nx     = k_q + 1'b1;
    assign lo_nx    = (k_nx >= n_q) ? idx_t'(k_nx - n_q + 1'b1) : '0;
    assign last_col = cnt_t'({n_q, 1'b0} - 2'd2);
    assign ext_lsb  = 2 * P * 32'(n_q);

    assign bus.in_ready     = (state_q == StIdle);
    assign bus.out_valid    = (state_q == StDone);
    assign bus.prod         = prod_q;
    assign init_sum         = '0;
    assign count_shift_input = '0;

    // Next-state, schedule walk, datapath strobes and digit capture.
    always_comb begin
        state_d           = state_q;
        n_d               = n_q;
        sgn_d             = sgn_q;
        k_d               = k_q;
        i_d               = i_q;
        dig_d             = dig_q;
        prod_d            = prod_q;
        start             = 1'b0;
        mux_sel_a         = '0;
        mux_sel_b         = '0;
        count_down        = 1'b0;
        count_last2       = 1'b0;
        last_out          = 1'b0;
        invert_first_bit  = 1'b0;
        invert_second_row = 1'b0;
        place_one         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    n_d     = n_req;
                    sgn_d   = bus.signed_i & SignedEn;
                    prod_d  = '0;
                    dig_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                start   = 1'b1;
                k_d     = '0;
                i_d     = '0;
                state_d = StRun;
            end
            StRun: begin
                mux_sel_a         = i_q;
                mux_sel_b         = j_cur;
                count_down        = (k_q >= n_q);
                count_last2       = (i_q == i_hi);
                invert_first_bit  = sgn_q && (i_q == nm1) && (j_cur != nm1);
                invert_second_row = sgn_q && (j_cur == nm1) && (i_q != nm1);
                // First pair of column N always has i == 1.
                place_one         = sgn_q && (k_q == n_q) && (i_q == 3'd1);
                if (count_last2) begin
                    if (k_q == last_col) begin
                        state_d = StLast;
                    end else begin
                        k_d = k_nx;
                        i_d = lo_nx;
                    end
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            StLast: begin
                last_out  = 1'b1;
                // With N=1 there is no column N, so the correction rides on last_out.
                place_one = sgn_q && (n_q == cnt_t'(1));
                state_d   = StFlush;
            end
            StFlush: state_d = StDone;
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // The datapath presents a column's digit one cycle after its end strobe.
        cap_d = count_last2 | last_out;
        if (cap_q) begin
            prod_d[dig_q*P +: P] = p;
            dig_d                = dig_q + 1'b1;
        end
        if (state_q == StFlush && sgn_q) begin
            for (int unsigned b = 0; b < PW; b++) begin
                if (b >= ext_lsb) prod_d[b] = p[P-1];
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            n_q     <= '0;
            sgn_q   <= 1'b0;
            k_q     <= '0;
            i_q     <= '0;
            dig_q   <= '0;
            cap_q   <= 1'b0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            sgn_q   <= sgn_d;
            k_q     <= k_d;
            i_q     <= i_d;
            dig_q   <= dig_d;
            cap_q   <= cap_d;
            prod_q  <= prod_d;
        end
    end
endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed bench for seq_mult_ctrl with a behavioural digit-serial datapath.
module tb_seq_mult_ctrl;
`ifdef SEQ_MULT_CTRL_SIGNED_EN
    localparam bit SignedEn = 1'b1;
`else
    localparam bit SignedEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] init_sum;
    logic [2:0] mux_sel_a, mux_sel_b;
    logic       count_down, count_last2, last_out;
    logic       invert_first_bit, invert_second_row, place_one;
    logic [1:0] count_shift_input;
    logic [1:0] p_m;

    int n_checks = 0;
    int n_bad    = 0;

    seq_mult_ctrl_if #(.P(2), .MAX_WIDTH(16)) bus ();

    seq_mult_ctrl #(.P(2), .MAX_WIDTH(16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .bus               (bus),
        .start             (start),
        .init_sum          (init_sum),
        .mux_sel_a         (mux_sel_a),
        .mux_sel_b         (mux_sel_b),
        .count_down        (count_down),
        .count_last2       (count_last2),
        .last_out          (last_out),
        .invert_first_bit  (invert_first_bit),
        .invert_second_row (invert_second_row),
        .place_one         (place_one),
        .count_shift_input (count_shift_input),
        .p                 (p_m)
    );

    always #5 clk = ~clk;

    // Datapath model: accumulate digit products per column, emit one digit per strobe.
    logic [15:0] a_m, b_m;
    int          n_m;
    bit          sg_m;
    int          acc_m;
    bit          run_m;
    int          sum_m;

    function automatic int dval(input logic [15:0] x, input int idx, input int n, input bit sg);
        int d;
        d = int'(x[idx*2 +: 2]);
        if (sg && idx == n - 1 && d >= 2) d = d - 4;
        return d;
    endfunction

    assign sum_m = acc_m + dval(a_m, int'(mux_sel_a), n_m, sg_m) *
                           dval(b_m, int'(mux_sel_b), n_m, sg_m);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_m <= 0;
            run_m <= 1'b0;
            p_m   <= '0;
        end else if (start) begin
            acc_m <= 0;
            run_m <= 1'b1;
        end else if (last_out) begin
            p_m   <= acc_m[1:0];
            run_m <= 1'b0;
        end else if (run_m) begin
            if (count_last2) begin
                p_m   <= sum_m[1:0];
                acc_m <= sum_m >>> 2;
            end else begin
                acc_m <= sum_m;
            end
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] part(input logic [31:0] x, input int cnt);
        logic [63:0] m;
        m = (64'd1 << (2 * cnt)) - 64'd1;
        return x & m[31:0];
    endfunction

    // One full transaction, checked cycle by cycle from accept to handshake.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] bsz,
                          input bit sg, input logic [31:0] exp, input int hold);
        int n;
        bit sge;
        int cnt;
        bit pend;
        bit strobe;
        logic [14:0] exp_v;
        n    = (bsz == 0 || bsz > 8) ? 8 : int'(bsz);
        sge  = SignedEn && sg;
        a_m  = a;
        b_m  = b;
        n_m  = n;
        sg_m = sge;
        check_val("idle", {bus.in_ready, bus.out_valid, start}, 3'b100);
        bus.in_valid = 1'b1;
        bus.bit_size = bsz;
        bus.signed_i = sg;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_val("start", {start, bus.in_ready, count_last2, last_out, bus.out_valid}, 5'b10000);
        check_val("start_prod", bus.prod, 32'h0);
        cnt    = 0;
        pend   = 1'b0;
        strobe = 1'b0;
        for (int k = 0; k <= 2 * n - 2; k++) begin
            int lo, hi;
            lo = (k >= n) ? k - n + 1 : 0;
            hi = (k < n) ? k : n - 1;
            for (int i = lo; i <= hi; i++) begin
                int j;
                j = k - i;
                if (pend) cnt++;
                pend = strobe;
                @(negedge clk);
                strobe = (i == hi);
                exp_v = {3'(i), 3'(j), strobe, (k >= n),
                         (sge && i == n - 1 && j != n - 1),
                         (sge && j == n - 1 && i != n - 1),
                         (sge && k == n && i == lo), 4'b0000};
                check_val("run", {mux_sel_a, mux_sel_b, count_last2, count_down,
                                  invert_first_bit, invert_second_row, place_one,
                                  start, last_out, bus.out_valid, bus.in_ready}, exp_v);
                check_val("run_prod", bus.prod, part(exp, cnt));
            end
        end
        if (pend) cnt++;
        pend = strobe;
        @(negedge clk);
        strobe = 1'b1;
        check_val("last", {last_out, place_one, count_last2, mux_sel_a, mux_sel_b, bus.out_valid},
                  {1'b1, (sge && n == 1), 8'h00});
        check_val("last_prod", bus.prod, part(exp, cnt));
        if (pend) cnt++;
        pend = strobe;
        @(negedge clk);
        strobe = 1'b0;
        check_val("flush", {last_out, place_one, bus.out_valid, bus.in_ready, start}, 5'b0);
        check_val("flush_prod", bus.prod, part(exp, cnt));
        @(negedge clk);
        check_val("done", {bus.out_valid, bus.in_ready, start, last_out}, 4'b1000);
        check_val("prod", bus.prod, exp);
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = (h % 2 == 1);
            bus.bit_size = 4'd1;
            @(negedge clk);
            check_val("hold", {bus.out_valid, bus.in_ready, start}, 3'b100);
            check_val("hold_prod", bus.prod, exp);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_val("back_idle", {bus.in_ready, bus.out_valid}, 2'b10);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val(tag, {start, count_last2, count_down, last_out, invert_first_bit,
                        invert_second_row, place_one, bus.out_valid, bus.in_ready,
                        mux_sel_a, mux_sel_b, count_shift_input, init_sum},
                  {8'b0000_0001, 16'h0});
        check_val({tag, "_prod"}, bus.prod, 32'h0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.bit_size  = '0;
        bus.signed_i  = 1'b0;
        bus.out_ready = 1'b0;
        a_m  = '0;
        b_m  = '0;
        n_m  = 8;
        sg_m = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_rel");

        run_op(16'hFFFF, 16'hFFFF, 4'd8, 1'b0, 32'hFFFE_0001, 0);
        run_op(16'h0003, 16'h0003, 4'd1, 1'b0, 32'h0000_0009, 0);
        run_op(16'h000B, 16'h0006, 4'd2, 1'b0, 32'h0000_0042, 0);
        run_op(16'h00FF, 16'h0002, 4'd4, 1'b1,
               SignedEn ? 32'hFFFF_FFFE : 32'h0000_01FE, 10);
        run_op(16'h1234, 16'h5678, 4'd0, 1'b0, 32'h0626_0060, 0);
        run_op(16'h00FF, 16'h0101, 4'd12, 1'b0, 32'h0000_FFFF, 0);
        run_op(16'h000B, 16'h0006, 4'd2, 1'b1,
               SignedEn ? 32'hFFFF_FFE2 : 32'h0000_0042, 0);

        // Reset asserted in the middle of RUN.
        a_m = 16'h1111;
        b_m = 16'h2222;
        n_m = 8;
        sg_m = 1'b0;
        bus.in_valid = 1'b1;
        bus.bit_size = 4'd8;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        check_val("mid_run_sel", {mux_sel_a, mux_sel_b}, {3'd2, 3'd0});
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_rel");
        run_op(16'hABCD, 16'h0003, 4'd8, 1'b0, 32'h0002_0367, 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
